prog_loader: RTL

Boot-time program loader for the single-cycle CPU. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into the instruction memory through its write port, and the CPU is held in reset until the whole image has landed. It is the write-side counterpart to the bench state dump: that dump reads PC, register and memory state out of the CPU, and this block drives the program in.

---
 rtl/prog_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a byte stream (32-bit LE word count, then LE words),
// writes each word into instruction memory and holds the CPU in reset until the image is in.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Stream handshake: a byte moves on a rising edge where in_valid && in_ready.
    // in_ready is registered and depends only on state, so a source may hold a byte
    // across WRITE and it is taken on the first DATA cycle.

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [31:0] CAP = 32'd1 << ADDR_W;

    state_t          state;
    logic [1:0]      byte_cnt;
    logic [31:0]     hdr;
    logic [31:0]     word;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] n_words;

    logic [31:0]     hdr_next;
    logic [31:0]     word_next;
    logic [ADDR_W:0] word_cnt_inc;

    // Little-endian assembly: each new byte enters at the top and shifts down.
    assign hdr_next     = {in_data, hdr[31:8]};
    assign word_next    = {in_data, word[31:8]};
    assign word_cnt_inc = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign dbg_state    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HDR;
            byte_cnt <= 2'd0;
            hdr      <= 32'd0;
            word     <= 32'd0;
            word_cnt <= '0;
            n_words  <= '0;
            in_ready <= 1'b1;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                HDR: begin
                    if (in_valid) begin
                        hdr      <= hdr_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (hdr_next == 32'd0) begin
                                state    <= DONE;
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                                cpu_rst  <= 1'b0;
                            end else if (hdr_next > CAP) begin
                                state    <= ERR;
                                in_ready <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                state    <= DATA;
                                word_cnt <= '0;
                                n_words  <= hdr_next[ADDR_W:0];
                            end
                        end
                    end
                end
                DATA: begin
                    if (in_valid) begin
                        word     <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            im_we    <= 1'b1;
                            im_addr  <= word_cnt[ADDR_W-1:0];
                            im_wdata <= word_next;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt_inc;
                    if (word_cnt_inc == n_words) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state    <= DATA;
                        in_ready <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        state    <= HDR;
                        byte_cnt <= 2'd0;
                        hdr      <= 32'd0;
                        word     <= 32'd0;
                        word_cnt <= '0;
                        n_words  <= '0;
                        in_ready <= 1'b1;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: begin
                    state    <= HDR;
                    byte_cnt <= 2'd0;
                    in_ready <= 1'b1;
                    cpu_rst  <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

endmodule
